// File: rtl/hram_bridge_pkg.sv
// hram_bridge_pkg: shared definitions for the UART to HyperRAM command bridge.
//   - command byte codes
//   - bridge and transmit sequencer state encodings
//   - all-ones error response fill (sliced to the word width by users)
//   - saturating increment helper for the 8-bit error counter
package hram_bridge_pkg;

   localparam logic [7:0] CMD_ADDR       = 8'h01;
   localparam logic [7:0] CMD_LOAD       = 8'h02;
   localparam logic [7:0] CMD_WRITE      = 8'h03;
   localparam logic [7:0] CMD_READ       = 8'h04;
   localparam logic [7:0] CMD_READ_REQ   = 8'h05;
   localparam logic [7:0] CMD_BURST_READ = 8'h08;
   localparam logic [7:0] CMD_STATUS     = 8'h09;

   localparam int unsigned MAX_WORD_BITS = 256;
   localparam logic [MAX_WORD_BITS-1:0] ERR_RESP = '1;

   typedef enum logic [2:0] {
      COLLECT,
      EXEC,
      MEM_REQ,
      MEM_WAIT,
      TX_SEND
   } bridge_state_e;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_LOAD,
      TX_STROBE,
      TX_WAIT
   } tx_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: sends one response word to uart_tx, MSB byte first.
//   clk, reset   : clock, synchronous active-high reset
//   load, word   : one-cycle strobe capturing the word to send
//   nbytes       : number of bytes to send from the top of the word
//   tx_ready     : uart_tx idle
//   tx_start     : one-cycle start strobe to uart_tx
//   tx_data      : byte presented with tx_start
//   done         : one-cycle pulse once the last byte has been taken
module uart_tx_seq
   import hram_bridge_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] word,
   input  logic [7:0]   nbytes,
   input  logic         tx_ready,
   output logic         tx_start,
   output logic [7:0]   tx_data,
   output logic         done
);

   tx_state_e    state_q, state_d;
   logic [W-1:0] shreg_q, shreg_d;
   logic [7:0]   cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TX_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      tx_start = 1'b0;
      done     = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (load) begin
               shreg_d = word;
               cnt_d   = nbytes;
               if (nbytes != 8'd0) state_d = TX_LOAD;
            end
         end
         TX_LOAD: begin
            if (tx_ready) state_d = TX_STROBE;
         end
         TX_STROBE: begin
            tx_start = 1'b1;
            state_d  = TX_WAIT;
         end
         TX_WAIT: begin
            // uart_tx dropping ready means it has taken the byte
            if (!tx_ready) begin
               shreg_d = shreg_q << 8;
               cnt_d   = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  done    = 1'b1;
                  state_d = TX_IDLE;
               end else begin
                  state_d = TX_LOAD;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign tx_data = shreg_q[W-1 -: 8];

endmodule

// File: rtl/uart_hram_bridge.sv
// uart_hram_bridge: decodes framed UART commands into HyperRAM controller
// requests and returns DATA_BYTES-long responses.
//   clk, reset          : clock, synchronous active-high reset
//   rx_rcv, rx_data     : received byte strobe and byte from uart_rx
//   tx_start, tx_data   : byte strobe and byte to uart_tx; tx_ready = uart_tx idle
//   mem_rd_req/wr_req   : one-cycle controller strobes
//   mem_addr, mem_wr_d  : access address and write data
//   mem_rd_d, mem_rd_rdy: read data and its valid strobe; mem_busy = controller busy
//   frame_err           : one-cycle pulse on any framing or command error
module uart_hram_bridge
   import hram_bridge_pkg::*;
#(
   parameter int unsigned DATA_BYTES     = 4,
   parameter int unsigned ADDR_STEP      = 1,
   parameter int unsigned MAX_BURST      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2400000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rx_rcv,
   input  logic [7:0]              rx_data,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   input  logic                    tx_ready,
   output logic                    mem_rd_req,
   output logic                    mem_wr_req,
   output logic [31:0]             mem_addr,
   output logic [8*DATA_BYTES-1:0] mem_wr_d,
   input  logic [8*DATA_BYTES-1:0] mem_rd_d,
   input  logic                    mem_rd_rdy,
   input  logic                    mem_busy,
   output logic                    frame_err
);

   localparam int unsigned W  = 8 * DATA_BYTES;
   localparam int unsigned CW = $clog2(DATA_BYTES + 2);

   bridge_state_e state_q, state_d;
   logic [CW-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [W-1:0]  payload_q, payload_d;
   logic [31:0]   tmo_q, tmo_d;
   logic [7:0]    err_count_q, err_count_d;
   logic [15:0]   cmd_count_q, cmd_count_d;
   logic [7:0]    last_cmd_q, last_cmd_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [W-1:0]  wr_data_q, wr_data_d;
   logic [W-1:0]  rdata_q, rdata_d;
   logic [W-1:0]  resp_q, resp_d;
   logic [W-1:0]  burst_left_q, burst_left_d;
   logic          seen_busy_q, seen_busy_d;
   logic          load_q, load_d;
   logic          frame_err_q, frame_err_d;

   logic expire;
   logic err_a;
   logic err_b;
   logic cmd_ok;
   logic cmd_bad;
   logic tx_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= COLLECT;
         byte_cnt_q   <= '0;
         cmd_q        <= '0;
         payload_q    <= '0;
         tmo_q        <= '0;
         err_count_q  <= '0;
         cmd_count_q  <= '0;
         last_cmd_q   <= '0;
         mem_addr_q   <= '0;
         wr_data_q    <= '0;
         rdata_q      <= '0;
         resp_q       <= '0;
         burst_left_q <= '0;
         seen_busy_q  <= 1'b0;
         load_q       <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         cmd_q        <= cmd_d;
         payload_q    <= payload_d;
         tmo_q        <= tmo_d;
         err_count_q  <= err_count_d;
         cmd_count_q  <= cmd_count_d;
         last_cmd_q   <= last_cmd_d;
         mem_addr_q   <= mem_addr_d;
         wr_data_q    <= wr_data_d;
         rdata_q      <= rdata_d;
         resp_q       <= resp_d;
         burst_left_q <= burst_left_d;
         seen_busy_q  <= seen_busy_d;
         load_q       <= load_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // a partial frame has sat idle for TIMEOUT_CYCLES clocks
   assign expire = (state_q == COLLECT) && (byte_cnt_q != '0) &&
                   (tmo_q >= 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      cmd_d        = cmd_q;
      payload_d    = payload_q;
      tmo_d        = '0;
      cmd_count_d  = cmd_count_q;
      last_cmd_d   = last_cmd_q;
      mem_addr_d   = mem_addr_q;
      wr_data_d    = wr_data_q;
      rdata_d      = rdata_q;
      resp_d       = resp_q;
      burst_left_d = burst_left_q;
      seen_busy_d  = seen_busy_q;
      load_d       = 1'b0;
      frame_err_d  = 1'b0;
      mem_rd_req   = 1'b0;
      mem_wr_req   = 1'b0;
      err_a        = 1'b0;
      err_b        = 1'b0;
      cmd_ok       = 1'b0;
      cmd_bad      = 1'b0;

      case (state_q)
         COLLECT: begin
            if (expire) begin
               frame_err_d = 1'b1;
               err_a       = 1'b1;
               byte_cnt_d  = '0;
            end
            if (rx_rcv) begin
               // on a simultaneous expiry the byte opens a fresh frame
               if (expire || byte_cnt_q == '0) begin
                  cmd_d      = rx_data;
                  payload_d  = '0;
                  byte_cnt_d = CW'(1);
               end else begin
                  payload_d = (payload_q << 8) | W'(rx_data);
                  if (byte_cnt_q == CW'(DATA_BYTES)) begin
                     byte_cnt_d = '0;
                     state_d    = EXEC;
                  end else begin
                     byte_cnt_d = byte_cnt_q + CW'(1);
                  end
               end
            end else if (!expire && byte_cnt_q != '0) begin
               tmo_d = tmo_q + 32'd1;
            end
         end

         EXEC: begin
            case (cmd_q)
               CMD_ADDR: begin
                  mem_addr_d = 32'(payload_q);
                  resp_d     = payload_q;
                  load_d     = 1'b1;
                  state_d    = TX_SEND;
                  cmd_ok     = 1'b1;
               end
               CMD_LOAD: begin
                  wr_data_d = payload_q;
                  resp_d    = payload_q;
                  load_d    = 1'b1;
                  state_d   = TX_SEND;
                  cmd_ok    = 1'b1;
               end
               CMD_WRITE, CMD_READ_REQ: begin
                  seen_busy_d = 1'b0;
                  state_d     = MEM_REQ;
                  cmd_ok      = 1'b1;
               end
               CMD_READ: begin
                  resp_d  = rdata_q;
                  load_d  = 1'b1;
                  state_d = TX_SEND;
                  cmd_ok  = 1'b1;
               end
               CMD_BURST_READ: begin
                  if (payload_q == '0 || payload_q > W'(MAX_BURST)) begin
                     cmd_bad = 1'b1;
                  end else begin
                     burst_left_d = payload_q;
                     state_d      = MEM_REQ;
                     cmd_ok       = 1'b1;
                  end
               end
               CMD_STATUS: begin
                  resp_d  = W'({cmd_count_q, last_cmd_q, err_count_q});
                  load_d  = 1'b1;
                  state_d = TX_SEND;
                  cmd_ok  = 1'b1;
               end
               default: cmd_bad = 1'b1;
            endcase
            if (cmd_bad) begin
               resp_d      = ERR_RESP[W-1:0];
               load_d      = 1'b1;
               frame_err_d = 1'b1;
               err_a       = 1'b1;
               state_d     = TX_SEND;
            end
            if (cmd_ok) begin
               cmd_count_d = cmd_count_q + 16'd1;
               last_cmd_d  = cmd_q;
            end
         end

         MEM_REQ: begin
            if (!mem_busy) begin
               if (cmd_q == CMD_WRITE) mem_wr_req = 1'b1;
               else                    mem_rd_req = 1'b1;
               state_d = MEM_WAIT;
            end
         end

         MEM_WAIT: begin
            if (cmd_q == CMD_WRITE) begin
               // completion is busy going high and then low again
               if (mem_busy) begin
                  seen_busy_d = 1'b1;
               end else if (seen_busy_q) begin
                  mem_addr_d = mem_addr_q + 32'(ADDR_STEP);
                  resp_d     = W'(CMD_WRITE);
                  load_d     = 1'b1;
                  state_d    = TX_SEND;
               end
            end else if (mem_rd_rdy) begin
               rdata_d    = mem_rd_d;
               mem_addr_d = mem_addr_q + 32'(ADDR_STEP);
               if (cmd_q == CMD_BURST_READ) begin
                  resp_d       = mem_rd_d;
                  burst_left_d = burst_left_q - W'(1);
               end else begin
                  resp_d = W'(CMD_READ_REQ);
               end
               load_d  = 1'b1;
               state_d = TX_SEND;
            end
         end

         TX_SEND: begin
            if (tx_done) state_d = (burst_left_q != '0) ? MEM_REQ : COLLECT;
         end

         default: state_d = COLLECT;
      endcase

      if (rx_rcv && state_q != COLLECT) begin
         frame_err_d = 1'b1;
         err_b       = 1'b1;
      end

      err_count_d = err_a ? sat_inc8(err_count_q) : err_count_q;
      if (err_b) err_count_d = sat_inc8(err_count_d);
   end

   uart_tx_seq #(
      .W(W)
   ) u_tx_seq (
      .clk      (clk),
      .reset    (reset),
      .load     (load_q),
      .word     (resp_q),
      .nbytes   (8'(DATA_BYTES)),
      .tx_ready (tx_ready),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .done     (tx_done)
   );

   assign mem_addr  = mem_addr_q;
   assign mem_wr_d  = wr_data_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_hram_bridge.sv
// tb_uart_hram_bridge: directed bench for uart_hram_bridge with behavioural
// uart_tx and HyperRAM controller models.
module tb_uart_hram_bridge;

   localparam int unsigned DB = 4;
   localparam int unsigned W  = 8 * DB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_rcv = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_ready = 1'b1;
   logic          mem_rd_req;
   logic          mem_wr_req;
   logic [31:0]   mem_addr;
   logic [W-1:0]  mem_wr_d;
   logic [W-1:0]  mem_rd_d = '0;
   logic          mem_rd_rdy = 1'b0;
   logic          mem_busy = 1'b0;
   logic          frame_err;

   int checks = 0;
   int errors = 0;

   logic [7:0]    txq[$];
   int            tx_starts = 0;
   int            rd_reqs = 0;
   int            wr_reqs = 0;
   int            fe_pulses = 0;
   int            strobe_viol = 0;
   logic [31:0]   wr_addr_seen = '0;
   logic [W-1:0]  wr_data_seen = '0;
   logic [31:0]   req_addr = '0;
   int            tx_hold = 0;
   int            mem_phase = 0;
   int            mem_left = 0;
   bit            rd_mode = 1'b0;

   always #5 clk = ~clk;

   uart_hram_bridge #(
      .DATA_BYTES     (DB),
      .ADDR_STEP      (1),
      .MAX_BURST      (16),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_rcv     (rx_rcv),
      .rx_data    (rx_data),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_addr   (mem_addr),
      .mem_wr_d   (mem_wr_d),
      .mem_rd_d   (mem_rd_d),
      .mem_rd_rdy (mem_rd_rdy),
      .mem_busy   (mem_busy),
      .frame_err  (frame_err)
   );

   // uart_tx and controller models, evaluated mid-cycle
   always @(negedge clk) begin
      if (reset) begin
         tx_ready   = 1'b1;
         tx_hold    = 0;
         mem_busy   = 1'b0;
         mem_rd_rdy = 1'b0;
         mem_phase  = 0;
      end else begin
         if (tx_start) begin
            txq.push_back(tx_data);
            tx_starts++;
            tx_ready = 1'b0;
            tx_hold  = 3;
         end else if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) tx_ready = 1'b1;
         end
         if (frame_err) fe_pulses++;
         if ((mem_rd_req || mem_wr_req) && mem_busy) strobe_viol++;
         if (mem_rd_req && mem_wr_req) strobe_viol++;
         mem_rd_rdy = 1'b0;
         case (mem_phase)
            0: begin
               if (mem_rd_req || mem_wr_req) begin
                  req_addr = mem_addr;
                  if (mem_rd_req) begin
                     rd_reqs++;
                     mem_phase = 1;
                  end else begin
                     wr_reqs++;
                     wr_addr_seen = mem_addr;
                     wr_data_seen = mem_wr_d;
                     mem_phase = 3;
                  end
                  mem_left = 3;
               end
            end
            1, 3: begin
               mem_busy = 1'b1;
               mem_left--;
               if (mem_left == 0) mem_phase = mem_phase + 1;
            end
            2: begin
               mem_busy   = 1'b0;
               mem_rd_rdy = 1'b1;
               mem_rd_d   = rd_mode ? W'(req_addr) : W'(32'hCAFEF00D);
               mem_phase  = 0;
            end
            4: begin
               mem_busy  = 1'b0;
               mem_phase = 0;
            end
            default: mem_phase = 0;
         endcase
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data = b;
      rx_rcv  = 1'b1;
      @(posedge clk); #1;
      rx_rcv  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
      send_byte(c);
      for (int i = 3; i >= 0; i--) send_byte(p[8*i +: 8]);
   endtask

   // an expired wait yields X so the following comparison fails
   task automatic recv_word(output logic [31:0] w);
      int n;
      logic [7:0] b0, b1, b2, b3;
      n = 0;
      while (txq.size() < 4 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (txq.size() < 4) begin
         w = 'x;
      end else begin
         b0 = txq.pop_front();
         b1 = txq.pop_front();
         b2 = txq.pop_front();
         b3 = txq.pop_front();
         w = {b0, b1, b2, b3};
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      txq.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: got %b expected 0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
      checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req: got %b expected 0", mem_rd_req); end
      checks++; if (mem_wr_req !== 1'b0) begin errors++; $display("FAIL rst_wr_req: got %b expected 0", mem_wr_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", mem_addr); end
      checks++; if (mem_wr_d !== 32'h0) begin errors++; $display("FAIL rst_wr_d: got %h expected 0", mem_wr_d); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b expected 0", frame_err); end
      reset = 1'b0;
   endtask

   task automatic test_write();
      logic [31:0] w;
      int base_wr;
      base_wr = wr_reqs;
      send_frame(8'h01, 32'h00000010); recv_word(w);
      checks++; if (w !== 32'h00000010) begin errors++; $display("FAIL wr_addr_echo: got %h expected 00000010", w); end
      send_frame(8'h02, 32'hDEADBEEF); recv_word(w);
      checks++; if (w !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_load_echo: got %h expected deadbeef", w); end
      send_frame(8'h03, 32'h00000000); recv_word(w);
      checks++; if (w !== 32'h00000003) begin errors++; $display("FAIL wr_resp: got %h expected 00000003", w); end
      checks++; if (wr_reqs - base_wr != 1) begin errors++; $display("FAIL wr_req_count: got %0d expected 1", wr_reqs - base_wr); end
      checks++; if (wr_addr_seen !== 32'h10) begin errors++; $display("FAIL wr_req_addr: got %h expected 00000010", wr_addr_seen); end
      checks++; if (wr_data_seen !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_req_data: got %h expected deadbeef", wr_data_seen); end
      checks++; if (mem_addr !== 32'h11) begin errors++; $display("FAIL wr_addr_inc: got %h expected 00000011", mem_addr); end
   endtask

   task automatic test_read();
      logic [31:0] w;
      int base_tx;
      base_tx = tx_starts;
      rd_mode = 1'b0;
      send_frame(8'h01, 32'h00000010); recv_word(w);
      checks++; if (w !== 32'h00000010) begin errors++; $display("FAIL rd_addr_echo: got %h expected 00000010", w); end
      send_frame(8'h05, 32'h00000000); recv_word(w);
      checks++; if (w !== 32'h00000005) begin errors++; $display("FAIL rd_req_resp: got %h expected 00000005", w); end
      send_frame(8'h04, 32'h00000000); recv_word(w);
      checks++; if (w !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data: got %h expected cafef00d", w); end
      checks++; if (tx_starts - base_tx != 12) begin errors++; $display("FAIL rd_tx_count: got %0d expected 12", tx_starts - base_tx); end
      checks++; if (mem_addr !== 32'h11) begin errors++; $display("FAIL rd_addr_inc: got %h expected 00000011", mem_addr); end
   endtask

   task automatic test_burst();
      logic [31:0] w;
      int base_rd;
      rd_mode = 1'b1;
      send_frame(8'h01, 32'h00000020); recv_word(w);
      checks++; if (w !== 32'h00000020) begin errors++; $display("FAIL bu_addr_echo: got %h expected 00000020", w); end
      base_rd = rd_reqs;
      send_frame(8'h08, 32'h00000003);
      for (int k = 0; k < 3; k++) begin
         recv_word(w);
         checks++; if (w !== 32'h20 + 32'(k)) begin errors++; $display("FAIL bu_word%0d: got %h expected %h", k, w, 32'h20 + 32'(k)); end
      end
      repeat (20) @(posedge clk);
      #1;
      checks++; if (txq.size() != 0) begin errors++; $display("FAIL bu_extra_bytes: got %0d expected 0", txq.size()); end
      checks++; if (mem_addr !== 32'h23) begin errors++; $display("FAIL bu_addr_end: got %h expected 00000023", mem_addr); end
      checks++; if (rd_reqs - base_rd != 3) begin errors++; $display("FAIL bu_rd_count: got %0d expected 3", rd_reqs - base_rd); end
      checks++; if (strobe_viol != 0) begin errors++; $display("FAIL strobe_rules: got %0d expected 0", strobe_viol); end
   endtask

   task automatic test_errors();
      logic [31:0] w;
      int base_fe;
      do_reset();
      base_fe = fe_pulses;
      send_frame(8'h08, 32'h00000000); recv_word(w);
      checks++; if (w !== 32'hFFFFFFFF) begin errors++; $display("FAIL er_burst0: got %h expected ffffffff", w); end
      send_frame(8'h7F, 32'h12345678); recv_word(w);
      checks++; if (w !== 32'hFFFFFFFF) begin errors++; $display("FAIL er_badcmd: got %h expected ffffffff", w); end
      send_frame(8'h09, 32'h00000000); recv_word(w);
      checks++; if (w !== 32'h00000002) begin errors++; $display("FAIL er_status1: got %h expected 00000002", w); end
      checks++; if (fe_pulses - base_fe != 2) begin errors++; $display("FAIL er_fe_count: got %0d expected 2", fe_pulses - base_fe); end
      send_frame(8'h08, 32'h00000011); recv_word(w);
      checks++; if (w !== 32'hFFFFFFFF) begin errors++; $display("FAIL er_burst17: got %h expected ffffffff", w); end
      send_frame(8'h09, 32'h00000000); recv_word(w);
      checks++; if (w !== 32'h00010903) begin errors++; $display("FAIL er_status2: got %h expected 00010903", w); end
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      int base_fe;
      base_fe = fe_pulses;
      send_byte(8'h01);
      send_byte(8'hAA);
      repeat (150) @(posedge clk);
      #1;
      checks++; if (fe_pulses - base_fe != 1) begin errors++; $display("FAIL to_pulse: got %0d expected 1", fe_pulses - base_fe); end
      send_frame(8'h01, 32'h00000040); recv_word(w);
      checks++; if (w !== 32'h00000040) begin errors++; $display("FAIL to_resync: got %h expected 00000040", w); end
      checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL to_addr: got %h expected 00000040", mem_addr); end
      checks++; if (fe_pulses - base_fe != 1) begin errors++; $display("FAIL to_no_extra: got %0d expected 1", fe_pulses - base_fe); end
   endtask

   task automatic test_rx_busy();
      logic [31:0] w;
      int base_fe;
      base_fe = fe_pulses;
      send_frame(8'h01, 32'h00000050);
      send_byte(8'h33);
      recv_word(w);
      checks++; if (w !== 32'h00000050) begin errors++; $display("FAIL rb_echo: got %h expected 00000050", w); end
      checks++; if (fe_pulses - base_fe != 1) begin errors++; $display("FAIL rb_fe: got %0d expected 1", fe_pulses - base_fe); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      int n;
      int base_tx;
      int base_rd;
      rd_mode = 1'b1;
      send_frame(8'h01, 32'h00000020); recv_word(w);
      send_frame(8'h08, 32'h00000003);
      n = 0;
      while (txq.size() < 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      checks++; if (txq.size() < 2) begin errors++; $display("FAIL rm_burst_start: got %0d bytes expected 2", txq.size()); end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rm_tx_start: got %b expected 0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rm_tx_data: got %h expected 00", tx_data); end
      checks++; if (mem_rd_req !== 1'b0) begin errors++; $display("FAIL rm_rd_req: got %b expected 0", mem_rd_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h expected 0", mem_addr); end
      reset = 1'b0;
      base_tx = tx_starts;
      base_rd = rd_reqs;
      repeat (80) @(posedge clk);
      #1;
      checks++; if (tx_starts != base_tx) begin errors++; $display("FAIL rm_no_tx: got %0d expected %0d", tx_starts, base_tx); end
      checks++; if (rd_reqs != base_rd) begin errors++; $display("FAIL rm_no_rd: got %0d expected %0d", rd_reqs, base_rd); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_burst();
      test_errors();
      test_timeout();
      test_rx_busy();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_hram_bridge.md
Name: uart_hram_bridge

Overview:
- Parametrised successor to the board-level serial command interface; converts framed UART byte commands into HyperRAM controller requests and returns fixed-length responses.
- Sits between uart_rx/uart_tx and hyper_xface, all on the HyperRAM clock.
- Adds the following over the previous generation:
  - configurable word width
  - exact-length responses
  - auto-incrementing address
  - burst reads
  - inter-byte timeout resync
  - error/status reporting

Parameters:
- DATA_BYTES, 4: payload and response length in bytes; word width W = 8*DATA_BYTES.
- ADDR_STEP, 1: address increment applied after each completed memory access.
- MAX_BURST, 16: largest accepted BURST_READ count.
- TIMEOUT_CYCLES, 2400000: idle clocks after which a partial frame is discarded (100 ms at 24 MHz).

Ports:
- clk  in  1  HyperRAM/system clock
- reset  in  1  synchronous, active-high
- rx_rcv  in  1  one-cycle strobe, byte available from uart_rx
- rx_data  in  8  received byte
- tx_start  out  1  one-cycle strobe to uart_tx
- tx_data  out  8  byte to transmit
- tx_ready  in  1  uart_tx idle
- mem_rd_req  out  1  one-cycle read request
- mem_wr_req  out  1  one-cycle write request
- mem_addr  out  32  access address
- mem_wr_d  out  W  write data
- mem_rd_d  in  W  read data
- mem_rd_rdy  in  1  read data valid strobe
- mem_busy  in  1  controller busy
- frame_err  out  1  one-cycle pulse on any framing or command error

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values:
  - all outputs 0, mem_addr 0, mem_wr_d 0
  - state COLLECT; byte counter, timeout counter, err_count, cmd_count all 0
- Frame format:
  - 1 command byte, then DATA_BYTES payload bytes, MSB first.
  - The command executes the cycle after the last byte is received.
- Command codes (shared package):
  - ADDR 0x01: mem_addr <= payload; response echoes payload.
  - LOAD 0x02: mem_wr_d <= payload; response echoes payload.
  - WRITE 0x03: wait !mem_busy, pulse mem_wr_req, wait mem_busy high then low, mem_addr += ADDR_STEP; response 0x03 zero-extended.
  - READ_REQ 0x05: wait !mem_busy, pulse mem_rd_req, wait mem_rd_rdy, latch rdata, mem_addr += ADDR_STEP; response 0x05.
  - READ 0x04: response = rdata; no memory access.
  - BURST_READ 0x08: payload N. For N = 1..MAX_BURST, repeat N times: read as READ_REQ, then transmit the word. Total N*DATA_BYTES bytes, no header. N = 0 or N > MAX_BURST is an error.
  - STATUS 0x09: response bits[7:0] = err_count, [15:8] = last valid cmd, [31:16] = cmd_count[15:0] when W ≥ 32; upper bits zero.
  - Any other code: response all-ones (W bits), frame_err pulse, err_count +1.
- FSM states:
  - COLLECT → EXEC → (MEM_REQ → MEM_WAIT) → TX_LOAD → TX_STROBE → TX_WAIT → back to TX_LOAD or COLLECT.
  - After TX_WAIT, BURST_READ with words remaining returns to MEM_REQ.
- TX handshake:
  - TX_LOAD waits for tx_ready = 1.
  - TX_STROBE asserts tx_start for exactly one cycle with tx_data = response MSB byte.
  - TX_WAIT waits for tx_ready = 0, then shifts the response left 8 bits.
  - Exactly DATA_BYTES bytes are sent per word, never an extra byte.
- Memory strobes: mem_rd_req and mem_wr_req are never asserted together and never while mem_busy = 1.
- Timeout: counter clears on every rx_rcv. When it reaches TIMEOUT_CYCLES with 0 < bytes < DATA_BYTES+1, the frame is discarded, frame_err pulses, and err_count +1.
- rx_rcv outside COLLECT: byte dropped, frame_err pulse, err_count +1.
- Counters:
  - err_count saturates at 0xFF.
  - cmd_count wraps.
  - mem_addr wraps modulo 2^32.
- rx_rcv in the same cycle as a timeout expiry: the timeout wins, and the byte starts a new frame as its command byte.
- Reset mid-operation: returns to reset values immediately. Any in-flight controller access is abandoned, with no further strobes.

Decomposition:
- Shared package hram_bridge_pkg holds:
  - command code constants
  - FSM state encoding
  - error response constant
- One natural sub-module, uart_tx_seq: response shift register plus the tx_ready handshake. Inputs are load, word, and byte count; output is done.

Test Plan:
- Send 01 00 00 00 10, then 02 DE AD BE EF, then 03 00 00 00 00 → echoes 00000010 and DEADBEEF; mem_wr_req pulses once with addr 0x10, data DEADBEEF; response 00000003; mem_addr becomes 0x11.
- Send ADDR 0x10, READ_REQ, READ with a controller model returning CAFEF00D → responses 00000010, 00000005, CAFEF00D; exactly 12 tx_start pulses total.
- Send ADDR 0x20, then BURST_READ N = 3 with model data = address → 12 bytes 00000020 00000021 00000022; mem_addr ends at 0x23.
- Send BURST_READ N = 0, then command 0x7F, then STATUS → FFFFFFFF twice; STATUS byte0 = 0x02.
- Send 2 bytes, then idle for TIMEOUT_CYCLES (set to 100 in the bench) → single frame_err pulse; next full ADDR frame is accepted correctly.
- Assert reset during a BURST_READ transmit → all outputs 0 the next cycle; no further tx_start or mem_rd_req.
